axi_rd_arb: RTL

AXI_RD_ARB -- requirements
Module: axi_rd_arb

---
 rtl/axi_rd_arb.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_arb.sv
// Four-source AXI read-address arbiter with a one-entry AR register, per-source
// outstanding-burst limits and ID-routed R return. Optional macro AXI_RD_ARB_QOS_EN gives source 0 strict priority.
module axi_rd_arb #(
    parameter int NUM_SRC  = 4,
    parameter int MAX_OUTS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        s_arvalid,
    output logic [NUM_SRC-1:0]        s_arready,
    input  logic [NUM_SRC-1:0][15:0]  s_arid,
    input  logic [NUM_SRC-1:0][63:0]  s_araddr,
    input  logic [NUM_SRC-1:0][7:0]   s_arlen,
    input  logic [NUM_SRC-1:0][2:0]   s_arsize,
    output logic [NUM_SRC-1:0]        s_rvalid,
    input  logic [NUM_SRC-1:0]        s_rready,
    output logic [15:0]               s_rid,
    output logic [511:0]              s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [15:0]               m_arid,
    output logic [63:0]               m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [15:0]               m_rid,
    input  logic [511:0]              m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    output logic                      err_underflow
);

    logic                 ready_q;
    logic [1:0]           rr_ptr;
    logic [5:0]           outs [NUM_SRC];
    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   inc_vec;
    logic [NUM_SRC-1:0]   dec_vec;
    logic                 loadable;
    logic                 grant_any;
    logic                 grant;
    logic [1:0]           winner;
    logic [1:0]           idx;
    logic [1:0]           r_src;
    logic                 rbeat_last;
    logic                 unused_arid_hi;

    assign unused_arid_hi = ^{s_arid[0][15:14], s_arid[1][15:14],
                              s_arid[2][15:14], s_arid[3][15:14]};

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            eligible[i] = s_arvalid[i] && (outs[i] < 6'(MAX_OUTS));
    end

    // ready_q holds off grants until the second edge after reset release
    assign loadable = ready_q && (!m_arvalid || m_arready);

    always_comb begin
        grant_any = 1'b0;
        winner    = 2'd0;
        idx       = 2'd0;
`ifdef AXI_RD_ARB_QOS_EN
        if (eligible[0]) begin
            grant_any = 1'b1;
            winner    = 2'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = rr_ptr + 2'(k);
                if (!grant_any && idx != 2'd0 && eligible[idx]) begin
                    grant_any = 1'b1;
                    winner    = idx;
                end
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                winner    = idx;
            end
        end
`endif
    end

    assign grant = loadable && grant_any;

    always_comb begin
        s_arready         = '0;
        s_arready[winner] = grant;
    end

    assign r_src      = m_rid[15:14];
    assign m_rready   = s_rready[r_src];
    assign s_rid      = {2'b00, m_rid[13:0]};
    assign s_rdata    = m_rdata;
    assign s_rresp    = m_rresp;
    assign s_rlast    = m_rlast;
    assign rbeat_last = m_rvalid && m_rready && m_rlast;

    always_comb begin
        s_rvalid        = '0;
        s_rvalid[r_src] = m_rvalid;
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            inc_vec[i] = grant && (winner == 2'(i));
            dec_vec[i] = rbeat_last && (r_src == 2'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q       <= 1'b0;
            rr_ptr        <= 2'd0;
            m_arvalid     <= 1'b0;
            m_arid        <= '0;
            m_araddr      <= '0;
            m_arlen       <= '0;
            m_arsize      <= '0;
            err_underflow <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) outs[i] <= '0;
        end else begin
            ready_q <= 1'b1;
            if (grant) begin
                m_arvalid <= 1'b1;
                m_arid    <= {winner, s_arid[winner][13:0]};
                m_araddr  <= s_araddr[winner];
                m_arlen   <= s_arlen[winner];
                m_arsize  <= s_arsize[winner];
                rr_ptr    <= winner + 2'd1;
            end else if (m_arready) begin
                m_arvalid <= 1'b0;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    outs[i] <= outs[i] + 6'd1;
                else if (dec_vec[i] && !inc_vec[i] && outs[i] != 6'd0)
                    outs[i] <= outs[i] - 6'd1;
                // a last beat with nothing outstanding is a protocol error
                if (dec_vec[i] && outs[i] == 6'd0)
                    err_underflow <= 1'b1;
            end
        end
    end

endmodule
